// File: rtl/pip_rbs_sub.sv
// pip_rbs_sub: pipelined ripple-borrow subtractor, d = a - b - bin.
// WIDTH is cut into NCHUNK slices of CHUNK bits, one register stage per slice.
// Operand slices are skewed in, the borrow ripples through registers, and
// the difference slices are de-skewed so each word leaves aligned.
// Latency is NCHUNK+2 register levels: input, NCHUNK slices, output.
// A ce=0 cycle freezes every register.
// Optional feature: define PIP_RBS_OVF_EN to build the signed overflow flag;
// otherwise ovf is tied to 0.
module pip_rbs_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int STAGES = NCHUNK + 1;

  logic [WIDTH-1:0]             a_r, b_r;
  logic                         bin_r;
  logic [STAGES:0]              vld_pipe;
  logic [NCHUNK-1:0][CHUNK-1:0] aligned;

  // Input register and the valid chain, which moves in lockstep with the data
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      bin_r    <= 1'b0;
      vld_pipe <= '0;
    end else if (ce) begin
      a_r      <= a;
      b_r      <= b;
      bin_r    <= bin;
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
    end
  end

  assign out_valid = vld_pipe[STAGES];

  for (genvar k = 0; k < NCHUNK; k++) begin : g_slice
    localparam int DSK = NCHUNK - 1 - k;
    logic [CHUNK-1:0] opa, opb, diff_r;
    logic             bi, brw_r;
    logic [CHUNK:0]   sub;

    // Skew: slice k operands wait k cycles for the borrow of slice k-1
    if (k == 0) begin : g_noskew
      assign opa = a_r[k*CHUNK +: CHUNK];
      assign opb = b_r[k*CHUNK +: CHUNK];
      assign bi  = bin_r;
    end else begin : g_skew
      logic [k-1:0][CHUNK-1:0] a_sk, b_sk;
      // Operand skew shift register
      always_ff @(posedge clk) begin
        if (rst) begin
          a_sk <= '0;
          b_sk <= '0;
        end else if (ce) begin
          a_sk[0] <= a_r[k*CHUNK +: CHUNK];
          b_sk[0] <= b_r[k*CHUNK +: CHUNK];
          for (int j = 1; j < k; j++) begin
            a_sk[j] <= a_sk[j-1];
            b_sk[j] <= b_sk[j-1];
          end
        end
      end
      assign opa = a_sk[k-1];
      assign opb = b_sk[k-1];
      assign bi  = g_slice[k-1].brw_r;
    end

    // One extra bit on top of the slice captures its borrow out
    assign sub = {1'b0, opa} - {1'b0, opb} - {{CHUNK{1'b0}}, bi};

    // Slice stage: difference and borrow for this chunk
    always_ff @(posedge clk) begin
      if (rst) begin
        diff_r <= '0;
        brw_r  <= 1'b0;
      end else if (ce) begin
        diff_r <= sub[CHUNK-1:0];
        brw_r  <= sub[CHUNK];
      end
    end

    // De-skew: early slices wait so all slices line up for the output register
    if (DSK == 0) begin : g_nodsk
      assign aligned[k] = diff_r;
    end else begin : g_dsk
      logic [DSK-1:0][CHUNK-1:0] dsk;
      // Result de-skew shift register
      always_ff @(posedge clk) begin
        if (rst) begin
          dsk <= '0;
        end else if (ce) begin
          dsk[0] <= diff_r;
          for (int j = 1; j < DSK; j++) dsk[j] <= dsk[j-1];
        end
      end
      assign aligned[k] = dsk[DSK-1];
    end
  end

  // Output register; the top slice needs no de-skew so its borrow is in step
  always_ff @(posedge clk) begin
    if (rst) begin
      d    <= '0;
      bout <= 1'b0;
    end else if (ce) begin
      d    <= aligned;
      bout <= g_slice[NCHUNK-1].brw_r;
    end
  end

`ifdef PIP_RBS_OVF_EN
  logic [NCHUNK-1:0] am_p, bm_p;

  // Carry operand sign bits alongside the slices so ovf pairs with its d
  always_ff @(posedge clk) begin
    if (rst) begin
      am_p <= '0;
      bm_p <= '0;
      ovf  <= 1'b0;
    end else if (ce) begin
      am_p[0] <= a_r[WIDTH-1];
      bm_p[0] <= b_r[WIDTH-1];
      for (int j = 1; j < NCHUNK; j++) begin
        am_p[j] <= am_p[j-1];
        bm_p[j] <= bm_p[j-1];
      end
      ovf <= (am_p[NCHUNK-1] != bm_p[NCHUNK-1]) &&
             (aligned[NCHUNK-1][CHUNK-1] != am_p[NCHUNK-1]);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pip_rbs_sub.sv
// Scoreboard bench for pip_rbs_sub: a model process pushes expected results
// at each sampling edge; a monitor pops and compares when out_valid shows.
module tb_pip_rbs_sub;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int LAT   = WIDTH / CHUNK + 1;

  logic             clk = 1'b0;
  logic             rst, ce, in_valid, bin;
  logic [WIDTH-1:0] a, b;
  logic             out_valid, bout, ovf;
  logic [WIDTH-1:0] d;

  pip_rbs_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .bin(bin), .out_valid(out_valid), .d(d), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
    int               due;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0;
  int   ecnt = 0;
  logic last_ce = 1'b0, last_rst = 1'b1, started = 1'b0;
  logic [WIDTH-1:0] prev_d;
  logic prev_v, prev_b, prev_o;

  // Reference: whole-word arithmetic, borrow out is the sign of the wide result
  function automatic exp_t model(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic bi, int due);
    exp_t e;
    logic [WIDTH:0] r;
    r = {1'b0, x} - {1'b0, y} - (WIDTH+1)'(bi);
    e.d = r[WIDTH-1:0];
    e.bout = r[WIDTH];
`ifdef PIP_RBS_OVF_EN
    e.ovf = (x[WIDTH-1] != y[WIDTH-1]) && (e.d[WIDTH-1] != x[WIDTH-1]);
`else
    e.ovf = 1'b0;
`endif
    e.due = due;
    return e;
  endfunction

  // Model: counts enabled edges and queues each accepted operation
  always @(posedge clk) begin
    last_ce  = ce;
    last_rst = rst;
    if (rst) q.delete();
    else if (ce) begin
      ecnt++;
      if (in_valid) q.push_back(model(a, b, bin, ecnt + LAT));
    end
  end

  // Monitor: frozen check on stalled edges, scoreboard pop on valid outputs
  always @(negedge clk) begin
    if (started) begin
      if (!last_ce && !last_rst) begin
        tests++;
        if ({out_valid, d, bout, ovf} !== {prev_v, prev_d, prev_b, prev_o}) begin
          fails++;
          $display("FAIL stall_frozen: got v=%b d=%h b=%b o=%b, need v=%b d=%h b=%b o=%b",
                   out_valid, d, bout, ovf, prev_v, prev_d, prev_b, prev_o);
        end
      end else if (out_valid === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL stray_valid: got out_valid=1 d=%h, need out_valid=0", d);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (d !== e.d || bout !== e.bout || ovf !== e.ovf || ecnt != e.due) begin
            fails++;
            $display("FAIL result: got d=%h bout=%b ovf=%b at cycle %0d, need d=%h bout=%b ovf=%b at cycle %0d",
                     d, bout, ovf, ecnt, e.d, e.bout, e.ovf, e.due);
          end
        end
      end
    end
    prev_v = out_valid; prev_d = d; prev_b = bout; prev_o = ovf;
  end

  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi);
    in_valid = 1'b1; a = x; b = y; bin = bi;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    ce = 1'b1;
    while (q.size() != 0 && n < 60) begin
      idle(1);
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d results pending, need 0", q.size());
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({out_valid, d, bout, ovf} !== '0) begin
      fails++;
      $display("FAIL reset_state: got v=%b d=%h b=%b o=%b, need all zero", out_valid, d, bout, ovf);
    end
    rst = 1'b0;
    started = 1'b1;

    // Basic, wrap/borrow and full ripple
    issue(16'h0005, 16'h0003, 1'b0); idle(7);
    issue(16'h0000, 16'h0001, 1'b0); idle(7);
    issue(16'h1000, 16'h0FFF, 1'b1); idle(7);
    issue(16'h0000, 16'h0000, 1'b1); idle(7);
    issue(16'hABCD, 16'hABCD, 1'b0); idle(7);

    // Back-to-back
    issue(16'h0010, 16'h0001, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b0);
    issue(16'h1234, 16'h0234, 1'b0);
    idle(8);

    // Stall mid-flight
    issue(16'h00F0, 16'h000F, 1'b0);
    idle(2);
    ce = 1'b0; idle(2); ce = 1'b1;
    idle(8);

    // Reset mid-flight, with ce low during reset to show reset wins
    issue(16'h0100, 16'h0001, 1'b0);
    issue(16'h0200, 16'h0002, 1'b0);
    rst = 1'b1; ce = 1'b0;
    issue(16'h0300, 16'h0003, 1'b0);
    rst = 1'b0; ce = 1'b1;
    idle(8);
    issue(16'h0009, 16'h0004, 1'b0); idle(7);

    // Overflow corners
    issue(16'h8000, 16'h0001, 1'b0);
    issue(16'h7FFF, 16'hFFFF, 1'b0);
    idle(8);

    // Random traffic with stalls and occasional reset
    for (int i = 0; i < 400; i++) begin
      ce  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) != 0)
        issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      else
        idle(1);
    end
    rst = 1'b0;
    drain();
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, need finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/pip_rbs_sub.md
Name: pip_rbs_sub

Overview:
- Pipelined ripple-borrow subtractor computing d = a - b - bin over WIDTH bits, split into CHUNK-bit slices with one register stage per slice.
- Operand slices are skewed in, borrow ripples slice-to-slice through registers, and result slices are de-skewed so the whole word emerges aligned.
- Subtract-direction companion to the pipelined ripple-carry adder; used wherever a full-throughput difference is needed.
- Adds a valid pipeline and a clock-enable stall that the adder lacks.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits per pipeline slice; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  pipeline enable; 0 freezes every pipeline register.
- in_valid  input  1  a/b/bin carry a new operation this cycle.
- a  input  WIDTH  minuend, unsigned / two's complement.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  d/bout/ovf hold an aligned result.
- d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow out; 1 when a < b + bin, treating operands as unsigned.
- ovf  output  1  signed overflow flag; see Optional Feature.

Behaviour:
- Reset: clk and rst are synchronous, active-high; reset is sampled only on posedge clk. While rst=1 at an edge, every valid bit, skew/de-skew register, borrow register and output is cleared. Result: out_valid=0, d=0, bout=0, ovf=0. Reset overrides ce.
- Stage 0: when ce=1, a, b, bin and in_valid are registered.
- Slice k (k=0..NCHUNK-1):
  - Computed in stage k+1 as a CHUNK-bit subtract of a[k], b[k] with the borrow from slice k-1 (bin for k=0).
  - Slice-k operands are delayed k extra cycles to meet their borrow.
  - The slice-k difference is delayed NCHUNK-1-k cycles so all slices align at the output register.
- Latency: an operation sampled with in_valid=1, ce=1 at edge N produces out_valid=1 with its result after edge N+NCHUNK+1 (5 cycles at defaults), given ce=1 throughout.
- Throughput: one operation per cycle, back-to-back allowed. Results keep issue order, with no gaps beyond the input gaps.
- Valid tracking: in_valid travels a NCHUNK+1-deep shift chain in lockstep with the data. out_valid is the chain tail.
- Bubbles: data registers load regardless of in_valid. When out_valid=0, d/bout/ovf are don't-care for checking but must be deterministic.
- Stall: with ce=0 at an edge, no register changes, including outputs and out_valid. Each ce=0 cycle adds exactly one cycle of latency to every in-flight operation, and inputs in that cycle are ignored.
- Reset mid-operation: all in-flight operations are discarded and never emerge. The first valid input after rst deasserts sees the full latency.
- Widths: d = (a - b - bin) mod 2^WIDTH. Borrow per slice = 1 when the slice minuend < subtrahend + borrow-in. bout is the borrow of slice NCHUNK-1.
- Edge values:
  - a=b, bin=0 gives d=0, bout=0.
  - a=0, b=0, bin=1 gives d=all-ones, bout=1.

Optional Feature:
- Macro PIP_RBS_OVF_EN.
- Defined: ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]), with a, b being the operands of the same operation. It is aligned with d, cleared by reset, and frozen by ce=0. The operand MSBs are carried down the pipeline for this.
- Undefined: ovf is tied to 0 and no extra registers are built.

Test Plan:
- Basic: a=0x0005, b=0x0003, bin=0, in_valid pulse -> exactly 5 cycles later out_valid=1, d=0x0002, bout=0.
- Wrap and borrow: a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1.
  - a=0x1000, b=0x0FFF, bin=1 -> d=0x0000, bout=0 (borrow ripples across all slices).
- Back-to-back: issue (0x0010,0x0001), (0xFFFF,0xFFFF), (0x1234,0x0234) on consecutive cycles -> out_valid high 3 consecutive cycles with d=0x000F, 0x0000, 0x1000; bout=0,0,0.
- Stall: issue a=0x00F0, b=0x000F, then hold ce=0 for 2 cycles mid-flight -> result d=0x00E1 appears after 7 cycles; outputs stay frozen during ce=0.
- Reset mid-flight: issue 3 operations, assert rst for 1 cycle after the second -> no out_valid for any of them.
  - A fresh operation issued after reset (0x0009-0x0004) yields d=0x0005 at 5-cycle latency.
- Overflow (PIP_RBS_OVF_EN defined): a=0x8000, b=0x0001 -> d=0x7FFF, ovf=1, bout=0.
  - a=0x7FFF, b=0xFFFF -> d=0x8000, ovf=1, bout=1.
  - Macro undefined: ovf=0 for both.
